mrw_mem: RTL
============

MRW_MEM -- requirements
Module: mrw_mem

Interface
REQ-001 Parameter depth, default 64: number of words, 1..2^addrbits.
REQ-002 Parameter addrbits, default 6: address width per port.
REQ-003 Parameter width, default 8: word width.
REQ-004 Parameter readernum, default 2: number of read ports, >=1.
REQ-005 Parameter isSyncRead, default 1: 1 = registered read data, 0 = combinational read.
REQ-006 Parameter ruwMode, default 0: sync read-under-write result; 0 = old data, 1 = new (bypassed) data.
REQ-007 The block has one clock; reset is synchronous and active-high.
REQ-008 clock  input  1  sole clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 read_ens  input  readernum  per-port read enable, bit k = port k.
REQ-011 read_addrs  input  addrbits*readernum  port k address at [k*addrbits +: addrbits].
REQ-012 read_datas  output  width*readernum  port k data at [k*width +: width].
REQ-013 write_en  input  1  write enable.
REQ-014 write_addr  input  addrbits  write address.
REQ-015 write_data  input  width  write data.
REQ-016 write_mask  input  width  per-bit write mask; 1 = bit written.
REQ-017 init_busy  output  1  high while the post-reset clear sequence runs.

Function
REQ-018 The FSM SHALL have states CLEAR and READY; a clear counter clr_cnt of addrbits bits indexes the word being zeroed.
REQ-019 In CLEAR, each edge SHALL write 0 to memcore[clr_cnt]; when reset is low, clr_cnt SHALL increment; at clr_cnt==depth-1 with reset low, the FSM SHALL move to READY.
REQ-020 init_busy SHALL equal (state==CLEAR): high for exactly depth cycles after reset deasserts.
REQ-021 In CLEAR, write_en SHALL be ignored, sync read registers SHALL hold 0, and async read_datas SHALL be forced to 0.
REQ-022 In READY with write_en=1 and write_addr<depth, the edge SHALL update memcore[write_addr] = (old & ~write_mask) | (write_data & write_mask).
REQ-023 A write with write_addr>=depth SHALL be dropped; a read with address>=depth SHALL return 0.
REQ-024 isSyncRead=1: on an edge with read_ens[k]=1, port k data register SHALL load memcore[addr_k]; with read_ens[k]=0 it SHALL hold; latency is 1 cycle.
REQ-025 isSyncRead=1, same-edge write to addr_k: ruwMode=0 SHALL return the pre-write word; ruwMode=1 SHALL return the post-mask merged word.
REQ-026 isSyncRead=0: read_datas[k] SHALL be memcore[addr_k] combinationally, read_ens ignored; a write becomes visible after its edge.
REQ-027 Multiple ports reading the same address SHALL each return identical data with no priority or stall.
REQ-028 write_mask=0 with write_en=1 SHALL leave memory unchanged.

Reset
REQ-029 reset=1 at an edge SHALL set state=CLEAR, clr_cnt=0, all read data registers=0, and zero memcore[0].
REQ-030 Reset asserted mid-clear or in READY SHALL restart the full clear sequence from address 0; data written before reset SHALL read 0 after clear.
REQ-031 While reset is held, init_busy SHALL be 1 and read_datas SHALL be 0.

Verification (depth=64, addrbits=6, width=8, readernum=2)
REQ-032 Reset 1 cycle, then idle -> init_busy high for exactly 64 cycles then low; reading addrs 0..63 returns 0x00.
REQ-033 READY: write 0xA5 to addr 5, mask 0xFF; next cycle port0 reads 5, port1 reads 5 -> both 0xA5 one cycle later (sync).
REQ-034 addr 5 holds 0xA5; write 0x3C to addr 5, mask 0x0F, with port0 reading 5 on the same edge -> ruwMode=0 gives 0xA5, ruwMode=1 gives 0xAC; a later read gives 0xAC.
REQ-035 write_en=1 during init_busy (addr 3, 0xFF) -> ignored; after clear, addr 3 reads 0x00.
REQ-036 Reset pulsed at clear cycle 30 -> init_busy stays high 64 further cycles after deassertion; earlier data gone.
REQ-037 Sync port0 reads addr 7 (0x11), then read_ens[0]=0 while addr changes to 8 -> read_datas[7:0] holds 0x11.

Source files
------------

// File: rtl/mrw_mem.sv
// Multi-read, single-write word memory with a post-reset clear sequence.
// Read ports are either registered (1-cycle latency, selectable read-under-write
// behaviour) or combinational. Writes support a per-bit mask.
module mrw_mem #(
  parameter int unsigned depth     = 64,
  parameter int unsigned addrbits  = 6,
  parameter int unsigned width     = 8,
  parameter int unsigned readernum = 2,
  parameter bit          isSyncRead = 1'b1,
  parameter bit          ruwMode    = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [readernum-1:0]          read_ens,
  input  logic [addrbits*readernum-1:0] read_addrs,
  output logic [width*readernum-1:0]    read_datas,
  input  logic                          write_en,
  input  logic [addrbits-1:0]           write_addr,
  input  logic [width-1:0]              write_data,
  input  logic [width-1:0]              write_mask,
  output logic                          init_busy
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  localparam logic [addrbits-1:0] LastAddr = addrbits'(depth - 1);

  state_e              state_q, state_d;
  logic [addrbits-1:0] clr_cnt_q, clr_cnt_d;
  logic [width-1:0]    memcore [depth];

  logic                wr_valid;
  logic [width-1:0]    wr_merged;
  logic                mem_we;
  logic [addrbits-1:0] mem_waddr;
  logic [width-1:0]    mem_wdata;

  // State register and clear counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state: walk the clear counter through every word, then go ready
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) state_d = StReady;
      end
      StReady: ;
      default: state_d = StClear;
    endcase
  end

  // FSM outputs
  always_comb begin
    init_busy = (state_q == StClear);
  end

  // Write-port arbitration: reset zeroes word 0, clear zeroes the counted word,
  // otherwise a user write merges data under the mask
  always_comb begin
    wr_valid  = (state_q == StReady) && write_en && (32'(write_addr) < depth);
    wr_merged = (memcore[write_addr] & ~write_mask) | (write_data & write_mask);
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = wr_merged;
    if (reset) begin
      mem_we    = 1'b1;
      mem_waddr = '0;
      mem_wdata = '0;
    end else if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_valid) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array
  always_ff @(posedge clock) begin
    if (mem_we) memcore[mem_waddr] <= mem_wdata;
  end

  for (genvar k = 0; k < readernum; k++) begin : g_port
    logic [addrbits-1:0] addr;
    logic [width-1:0]    rd_word;

    assign addr = read_addrs[k*addrbits +: addrbits];

    // Array lookup; out-of-range addresses read as zero
    always_comb begin
      rd_word = '0;
      if (32'(addr) < depth) rd_word = memcore[addr];
    end

    if (isSyncRead) begin : g_sync
      logic [width-1:0] rdata_q, rdata_d;
      logic [width-1:0] rd_fresh;

      // Same-edge write to this address bypasses the merged word when ruwMode=1
      always_comb begin
        rd_fresh = rd_word;
        if (ruwMode && wr_valid && (write_addr == addr)) rd_fresh = wr_merged;
        rdata_d = rdata_q;
        if (state_q == StClear) rdata_d = '0;
        else if (read_ens[k]) rdata_d = rd_fresh;
      end

      // Read data register
      always_ff @(posedge clock) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
      end

      assign read_datas[k*width +: width] = rdata_q;
    end else begin : g_async
      assign read_datas[k*width +: width] = (reset || state_q == StClear) ? '0 : rd_word;
    end
  end

endmodule
